reg_dec_chk: RTL and testbench
==============================

REG_DEC_CHK -- requirements
Module: reg_dec_chk

Checker for the 8-bit decrementing count stream: samples the data, verifies each value is the previous value minus one, and reports lock, errors and wrap events.

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 4, meaning the number of consecutive correct decrements needed to declare lock (range 1..15).
REQ-002 SHALL have parameter MISS_MAX, default 2, meaning the number of consecutive mismatches while locked that drops lock (range 1..15).
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: sample qualifier; i_data is evaluated only on edges where enable=1.
REQ-006 SHALL have port i_data, input, 8 bits: the count value under check.
REQ-007 SHALL have port i_clr, input, 1 bit: synchronous clear of both statistics counters.
REQ-008 SHALL have port o_locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-009 SHALL have port o_err, output, 1 bit: one-cycle pulse for each mismatch detected in LOCKED.
REQ-010 SHALL have port o_wrap, output, 1 bit: one-cycle pulse for each correct 0 -> 255 transition detected in LOCKED.
REQ-011 SHALL have port o_err_cnt, output, 8 bits: count of mismatches, saturating.
REQ-012 SHALL have port o_wrap_cnt, output, 8 bits: count of wraps, modulo 256.
REQ-013 SHALL have port o_state, output, 2 bits: FSM state, encoded IDLE=0, ACQ=1, LOCKED=2.

Function
REQ-014 SHALL define the expected value as (prev - 1) mod 256, where prev is the last sample taken; prev 0 expects 255.
REQ-015 SHALL load prev with i_data on every sampled edge, in every state, whether or not the sample matched.
REQ-016 SHALL register all outputs; a sample on edge N SHALL be reflected on the outputs immediately after edge N.
REQ-017 SHALL, with enable=0, hold all state and counters, take no sample, and drive o_err=0 and o_wrap=0.
REQ-018 SHALL, in IDLE, take the first sample as prev, clear match_cnt and move to ACQ.
REQ-019 SHALL, in ACQ, increment match_cnt on a match and clear it on a mismatch.
REQ-020 SHALL, in ACQ, move to LOCKED and clear miss_cnt when a match brings match_cnt to LOCK_LEN.
REQ-021 SHALL, in ACQ, raise neither o_err nor o_wrap and change neither counter.
REQ-022 SHALL, in LOCKED, clear miss_cnt on a match; if that match has i_data=255, it SHALL pulse o_wrap and increment o_wrap_cnt.
REQ-023 SHALL, in LOCKED, on a mismatch pulse o_err, increment o_err_cnt (saturating at 255) and increment miss_cnt.
REQ-024 SHALL, when a mismatch brings miss_cnt to MISS_MAX, move to ACQ with match_cnt=0; o_err SHALL still pulse on that edge.
REQ-025 SHALL, when i_clr=1, load 0 into both counters on that edge; a simultaneous error or wrap SHALL still pulse its output, but the counter SHALL read 0.
REQ-026 SHALL NOT let i_clr affect the FSM state, prev, match_cnt or miss_cnt.
REQ-027 SHALL treat a repeated value (i_data = prev) and an upward step as mismatches.

Reset
REQ-028 SHALL, while i_rst=1, immediately and regardless of the clock, force state IDLE, prev, match_cnt and miss_cnt to 0, and all outputs to 0 (o_state=0).
REQ-029 SHALL, on reset asserted mid-operation (including while LOCKED), drop o_locked asynchronously and discard all history; re-acquisition SHALL restart from IDLE.

Verification
REQ-030 SHALL cover lock acquisition: with default parameters, enable=1 and data 10,9,8,7,6 -> o_state goes 1 after 10; o_locked=1 right after the edge sampling 6, not earlier.
REQ-031 SHALL cover error and lock loss: when locked at prev=6, data 0x50 -> one-cycle o_err, o_err_cnt=1, still locked; next data 0x20 -> second o_err pulse, o_err_cnt=2, o_state=1, o_locked=0.
REQ-032 SHALL cover wrap: when locked, data 1,0,255,254 -> exactly one o_wrap pulse, on the 255 edge; o_wrap_cnt=1; o_err stays 0.
REQ-033 SHALL cover the enable gap: when locked, enable=0 for 3 cycles with random data -> all outputs unchanged; resuming with prev-1 -> still locked, no error.
REQ-034 SHALL cover saturation and clear: 300 mismatches (with MISS_MAX set to 15 and relocking in between) -> o_err_cnt holds 255; i_clr together with an error -> o_err pulses and o_err_cnt=0.
REQ-035 SHALL cover asynchronous reset: i_rst pulsed for 5 ns between clock edges while locked -> o_locked, o_state and both counters are 0 before the next edge.

Source files
------------

// File: rtl/reg_dec_chk.sv
// rtl/reg_dec_chk.sv - lock/error/wrap checker for an 8-bit decrementing count stream
module reg_dec_chk #(
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned MISS_MAX = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       enable,
  input  logic [7:0] i_data,
  input  logic       i_clr,
  output logic       o_locked,
  output logic       o_err,
  output logic       o_wrap,
  output logic [7:0] o_err_cnt,
  output logic [7:0] o_wrap_cnt,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] LOCK_LEN_C = 5'(LOCK_LEN);
  localparam logic [4:0] MISS_MAX_C = 5'(MISS_MAX);

  state_t     state;
  logic [7:0] prev;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;

  logic [7:0] expected;
  logic       match;
  logic [4:0] match_inc;
  logic [4:0] miss_inc;

  // Expected next value and the incremented run counters, widened so a
  // parameter of 15 compares without overflow.
  always_comb begin
    expected  = prev - 8'd1;
    match     = (i_data == expected);
    match_inc = {1'b0, match_cnt} + 5'd1;
    miss_inc  = {1'b0, miss_cnt} + 5'd1;
  end

  assign o_state = state;

  // Single FSM: sampling, lock tracking, pulse outputs and statistics counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      prev       <= 8'd0;
      match_cnt  <= 4'd0;
      miss_cnt   <= 4'd0;
      o_locked   <= 1'b0;
      o_err      <= 1'b0;
      o_wrap     <= 1'b0;
      o_err_cnt  <= 8'd0;
      o_wrap_cnt <= 8'd0;
    end else begin
      o_err  <= 1'b0;
      o_wrap <= 1'b0;
      if (enable) begin
        // Every sample becomes the reference for the next one, match or not.
        prev <= i_data;
        case (state)
          IDLE: begin
            match_cnt <= 4'd0;
            state     <= ACQ;
            o_locked  <= 1'b0;
          end
          ACQ: begin
            if (match) begin
              match_cnt <= match_inc[3:0];
              if (match_inc == LOCK_LEN_C) begin
                state    <= LOCKED;
                o_locked <= 1'b1;
                miss_cnt <= 4'd0;
              end
            end else begin
              match_cnt <= 4'd0;
            end
          end
          LOCKED: begin
            if (match) begin
              miss_cnt <= 4'd0;
              if (i_data == 8'hFF) begin
                o_wrap     <= 1'b1;
                o_wrap_cnt <= o_wrap_cnt + 8'd1;
              end
            end else begin
              o_err <= 1'b1;
              if (o_err_cnt != 8'hFF) begin
                o_err_cnt <= o_err_cnt + 8'd1;
              end
              miss_cnt <= miss_inc[3:0];
              if (miss_inc == MISS_MAX_C) begin
                state     <= ACQ;
                o_locked  <= 1'b0;
                match_cnt <= 4'd0;
              end
            end
          end
          default: begin
            state    <= IDLE;
            o_locked <= 1'b0;
          end
        endcase
      end
      // Clear overrides any increment on the same edge; pulses are untouched.
      if (i_clr) begin
        o_err_cnt  <= 8'd0;
        o_wrap_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_reg_dec_chk.sv
// tb/tb_reg_dec_chk.sv - directed self-checking bench for reg_dec_chk
module tb_reg_dec_chk;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       enable;
  logic [7:0] i_data;
  logic       i_clr;

  logic       o_locked, o_err, o_wrap;
  logic [7:0] o_err_cnt, o_wrap_cnt;
  logic [1:0] o_state;

  logic       locked2, err2, wrap2;
  logic [7:0] err_cnt2, wrap_cnt2;
  logic [1:0] state2;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  reg_dec_chk dut (
    .i_clk(i_clk), .i_rst(i_rst), .enable(enable), .i_data(i_data), .i_clr(i_clr),
    .o_locked(o_locked), .o_err(o_err), .o_wrap(o_wrap),
    .o_err_cnt(o_err_cnt), .o_wrap_cnt(o_wrap_cnt), .o_state(o_state)
  );

  reg_dec_chk #(.LOCK_LEN(4), .MISS_MAX(15)) dut15 (
    .i_clk(i_clk), .i_rst(i_rst), .enable(enable), .i_data(i_data), .i_clr(i_clr),
    .o_locked(locked2), .o_err(err2), .o_wrap(wrap2),
    .o_err_cnt(err_cnt2), .o_wrap_cnt(wrap_cnt2), .o_state(state2)
  );

  task automatic cyc(input logic en, input logic [7:0] d, input logic clr);
    enable = en;
    i_data = d;
    i_clr  = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; enable = 1'b0; i_data = 8'd0; i_clr = 1'b0;
    #2;
    checks++;
    if ({o_locked, o_err, o_wrap, o_err_cnt, o_wrap_cnt, o_state} !== 21'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {o_locked, o_err, o_wrap, o_err_cnt, o_wrap_cnt, o_state});
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic test_lock();
    cyc(1'b1, 8'd10, 1'b0);
    checks++;
    if (o_state !== 2'd1 || o_locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_first got state=%0d locked=%0b exp state=1 locked=0", o_state, o_locked);
    end
    for (int d = 9; d >= 7; d--) begin
      cyc(1'b1, 8'(d), 1'b0);
      checks++;
      if (o_state !== 2'd1 || o_locked !== 1'b0) begin
        failures++;
        $display("FAIL lock_early d=%0d got state=%0d locked=%0b exp state=1 locked=0", d, o_state, o_locked);
      end
    end
    cyc(1'b1, 8'd6, 1'b0);
    checks++;
    if (o_state !== 2'd2 || o_locked !== 1'b1) begin
      failures++;
      $display("FAIL lock_done got state=%0d locked=%0b exp state=2 locked=1", o_state, o_locked);
    end
  endtask

  task automatic test_error();
    cyc(1'b1, 8'h50, 1'b0);
    checks++;
    if (o_err !== 1'b1 || o_err_cnt !== 8'd1 || o_locked !== 1'b1) begin
      failures++;
      $display("FAIL err_first got err=%0b cnt=%0d locked=%0b exp 1 1 1", o_err, o_err_cnt, o_locked);
    end
    cyc(1'b1, 8'h20, 1'b0);
    checks++;
    if (o_err !== 1'b1 || o_err_cnt !== 8'd2 || o_state !== 2'd1 || o_locked !== 1'b0) begin
      failures++;
      $display("FAIL err_loss got err=%0b cnt=%0d state=%0d locked=%0b exp 1 2 1 0",
               o_err, o_err_cnt, o_state, o_locked);
    end
    checks++;
    if (locked2 !== 1'b1 || err_cnt2 !== 8'd2) begin
      failures++;
      $display("FAIL err_miss15 got locked=%0b cnt=%0d exp 1 2", locked2, err_cnt2);
    end
    cyc(1'b1, 8'h1F, 1'b0);
    checks++;
    if (o_err !== 1'b0 || o_state !== 2'd1) begin
      failures++;
      $display("FAIL err_acq got err=%0b state=%0d exp 0 1", o_err, o_state);
    end
    cyc(1'b1, 8'h1E, 1'b0);
    cyc(1'b1, 8'h1D, 1'b0);
    cyc(1'b1, 8'h1C, 1'b0);
    checks++;
    if (o_locked !== 1'b1 || o_err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL err_relock got locked=%0b cnt=%0d exp 1 2", o_locked, o_err_cnt);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    for (int d = 27; d >= 0; d--) begin
      cyc(1'b1, 8'(d), 1'b0);
      if (o_err !== 1'b0 || o_wrap !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wrap_descend got bad_cycles=%0d exp 0", bad);
    end
    cyc(1'b1, 8'd255, 1'b0);
    checks++;
    if (o_wrap !== 1'b1 || o_wrap_cnt !== 8'd1 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_pulse got wrap=%0b cnt=%0d err=%0b exp 1 1 0", o_wrap, o_wrap_cnt, o_err);
    end
    cyc(1'b1, 8'd254, 1'b0);
    checks++;
    if (o_wrap !== 1'b0 || o_wrap_cnt !== 8'd1 || o_err !== 1'b0 || o_locked !== 1'b1) begin
      failures++;
      $display("FAIL wrap_after got wrap=%0b cnt=%0d err=%0b locked=%0b exp 0 1 0 1",
               o_wrap, o_wrap_cnt, o_err, o_locked);
    end
  endtask

  task automatic test_enable_gap();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 8'($urandom), 1'b0);
      checks++;
      if ({o_locked, o_err, o_wrap, o_err_cnt, o_wrap_cnt, o_state} !== {1'b1, 1'b0, 1'b0, 8'd2, 8'd1, 2'd2}) begin
        failures++;
        $display("FAIL gap_hold k=%0d got=%h exp=%h", k,
                 {o_locked, o_err, o_wrap, o_err_cnt, o_wrap_cnt, o_state},
                 {1'b1, 1'b0, 1'b0, 8'd2, 8'd1, 2'd2});
      end
    end
    cyc(1'b1, 8'd253, 1'b0);
    checks++;
    if (o_locked !== 1'b1 || o_err !== 1'b0 || o_err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL gap_resume got locked=%0b err=%0b cnt=%0d exp 1 0 2", o_locked, o_err, o_err_cnt);
    end
  endtask

  task automatic test_sat_clear();
    logic [7:0] v;
    v = 8'd253;
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, v, 1'b0);
      v = v - 8'd1;
      cyc(1'b1, v, 1'b0);
    end
    checks++;
    if (err_cnt2 !== 8'd255 || locked2 !== 1'b1) begin
      failures++;
      $display("FAIL sat_miss15 got cnt=%0d locked=%0b exp 255 1", err_cnt2, locked2);
    end
    checks++;
    if (o_err_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_default got cnt=%0d exp 255", o_err_cnt);
    end
    cyc(1'b1, v, 1'b1);
    checks++;
    if (err2 !== 1'b1 || err_cnt2 !== 8'd0 || wrap_cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL clr_with_err got err=%0b cnt=%0d wrap_cnt=%0d exp 1 0 0", err2, err_cnt2, wrap_cnt2);
    end
    checks++;
    if (o_err !== 1'b1 || o_err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clr_default got err=%0b cnt=%0d exp 1 0", o_err, o_err_cnt);
    end
    v = v - 8'd1;
    cyc(1'b1, v, 1'b0);
  endtask

  task automatic test_async_reset();
    checks++;
    if (o_locked !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre got locked=%0b exp 1", o_locked);
    end
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_locked !== 1'b0 || o_state !== 2'd0 || o_err_cnt !== 8'd0 || o_wrap_cnt !== 8'd0) begin
      failures++;
      $display("FAIL areset_mid got locked=%0b state=%0d err_cnt=%0d wrap_cnt=%0d exp 0 0 0 0",
               o_locked, o_state, o_err_cnt, o_wrap_cnt);
    end
    #4;
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_locked !== 1'b0 || o_state !== 2'd0 || locked2 !== 1'b0) begin
      failures++;
      $display("FAIL areset_post got locked=%0b state=%0d locked2=%0b exp 0 0 0", o_locked, o_state, locked2);
    end
    @(posedge i_clk);
    #1;
    cyc(1'b1, 8'd100, 1'b0);
    checks++;
    if (o_state !== 2'd1 || o_locked !== 1'b0) begin
      failures++;
      $display("FAIL areset_reacq got state=%0d locked=%0b exp 1 0", o_state, o_locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_error();
    test_wrap();
    test_enable_gap();
    test_sat_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
